pipe_adder: RTL



---
 rtl/pipe_adder_pkg.sv | 23 ++
 rtl/pipe_adder_stage.sv | 28 ++
 rtl/pipe_adder.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/pipe_adder_pkg.sv
// ---------------------------------------------------------------------------
// pipe_adder_pkg
//   Shared definitions for the pipelined add/subtract unit.
//   - adder_op_e  : operation select (ADD / SUB)
//   - MAX_STAGES  : deepest supported pipeline
//   - params_ok() : elaboration-time check of WIDTH / STAGES legality
// ---------------------------------------------------------------------------
package pipe_adder_pkg;

  localparam int MAX_STAGES = 8;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } adder_op_e;

  // WIDTH must split into STAGES equal chunks and the depth must be in range.
  function automatic bit params_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= MAX_STAGES) &&
           (width > 0) && ((width % stages) == 0);
  endfunction

endpackage : pipe_adder_pkg

// File: rtl/pipe_adder_stage.sv
// ---------------------------------------------------------------------------
// pipe_adder_stage
//   CHUNK-wide combinational ripple add with carry in/out.
//   Ports:
//     a_i, b_i   : chunk operands (b already inverted for subtract)
//     cin_i      : carry into the chunk LSB
//     sum_o      : chunk sum
//     cout_o     : carry out of the chunk MSB
//     msb_cin_o  : carry into the chunk MSB (used for signed overflow)
// ---------------------------------------------------------------------------
module pipe_adder_stage #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o,
  output logic             msb_cin_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, cin_i};

  // Sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out of the
  // MSB sum bit; this also works when CHUNK is a single bit.
  assign msb_cin_o = a_i[CHUNK-1] ^ b_i[CHUNK-1] ^ sum_o[CHUNK-1];

endmodule : pipe_adder_stage

// File: rtl/pipe_adder.sv
// ---------------------------------------------------------------------------
// pipe_adder
//   Pipelined ripple-carry add/subtract unit. The WIDTH-bit operation is
//   split into STAGES chunks; each stage adds one chunk and registers the
//   partial result, the chunk carry and the not-yet-added operand bits.
//   Valid/ready handshake with bubble collapsing between stages.
//   Ports:
//     clk, rst_n            : clock, synchronous active-low reset
//     in_valid / in_ready   : operand beat handshake
//     in_a, in_b            : operands
//     in_cin                : carry-in (add) / borrow-in (subtract)
//     in_sub                : 0 = add, 1 = subtract
//     out_valid / out_ready : result beat handshake
//     out_sum               : result
//     out_cout              : MSB carry out (subtract: 1 = no borrow)
//     out_ovf               : two's-complement signed overflow
// ---------------------------------------------------------------------------
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int CHUNK = WIDTH / STAGES;

  if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
    $fatal(1, "pipe_adder: WIDTH must be a multiple of STAGES and STAGES in 1..MAX_STAGES");
  end

  // Subtract is a + ~b + !cin: inversion happens once here, so every stage
  // downstream is a plain adder.
  adder_op_e        op;
  logic [WIDTH-1:0] eff_b;
  logic             eff_cin;

  assign op      = adder_op_e'(in_sub);
  assign eff_b   = (op == SUB) ? ~in_b : in_b;
  assign eff_cin = (op == SUB) ? ~in_cin : in_cin;

  // ---------------------------------------------------------------------
  // Handshake: each stage is ready when empty or when the next one moves.
  // ---------------------------------------------------------------------
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] up_valid;
  logic [STAGES:0]   stage_ready;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    stage_ready         = '0;
    up_valid            = '0;
    stage_ready[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      stage_ready[k] = !valid_q[k] || stage_ready[k+1];
    end
    up_valid[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      up_valid[k] = valid_q[k-1];
    end
  end

  // NOTE: sequential state is always assigned with <= so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (stage_ready[k]) valid_q[k] <= up_valid[k];
      end
    end
  end

  assign in_ready  = stage_ready[0];
  assign out_valid = valid_q[STAGES-1];

  // ---------------------------------------------------------------------
  // Datapath. acc holds finished sum bits below the current chunk and the
  // untouched A bits above it; b carries the effective B along.
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] stage_acc   [STAGES];
  logic [WIDTH-1:0] stage_b     [STAGES];
  logic             stage_carry [STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] acc_in;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic [WIDTH-1:0] acc_nxt;
    logic [CHUNK-1:0] s_chunk;
    logic             c_out;
    logic             msb_cin;
    logic             load;

    if (k == 0) begin : g_first
      assign acc_in = in_a;
      assign b_in   = eff_b;
      assign c_in   = eff_cin;
    end else begin : g_next
      assign acc_in = stage_acc[k-1];
      assign b_in   = stage_b[k-1];
      assign c_in   = stage_carry[k-1];
    end

    pipe_adder_stage #(.CHUNK(CHUNK)) u_stage (
      .a_i       (acc_in[k*CHUNK +: CHUNK]),
      .b_i       (b_in[k*CHUNK +: CHUNK]),
      .cin_i     (c_in),
      .sum_o     (s_chunk),
      .cout_o    (c_out),
      .msb_cin_o (msb_cin)
    );

    always_comb begin
      acc_nxt                   = acc_in;
      acc_nxt[k*CHUNK +: CHUNK] = s_chunk;
    end

    // Data registers load only on a transfer into this stage.
    assign load = up_valid[k] && stage_ready[k];

    if (k == STAGES - 1) begin : g_last
      logic [WIDTH-1:0] sum_q;
      logic             cout_q;
      logic             ovf_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sum_q  <= '0;
          cout_q <= 1'b0;
          ovf_q  <= 1'b0;
        end else if (load) begin
          sum_q  <= acc_nxt;
          cout_q <= c_out;
          ovf_q  <= msb_cin ^ c_out;
        end
      end

      assign out_sum  = sum_q;
      assign out_cout = cout_q;
      assign out_ovf  = ovf_q;
    end else begin : g_mid
      logic [WIDTH-1:0] acc_q;
      logic [WIDTH-1:0] b_q;
      logic             carry_q;

      // NOTE: intermediate data registers carry no reset; their contents
      // are only observed when the matching valid bit (which is reset) is set.
      always_ff @(posedge clk) begin
        if (load) begin
          acc_q   <= acc_nxt;
          b_q     <= b_in;
          carry_q <= c_out;
        end
      end

      assign stage_acc[k]   = acc_q;
      assign stage_b[k]     = b_q;
      assign stage_carry[k] = carry_q;
    end
  end

endmodule : pipe_adder
